vga_sync_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock. The pixel-rate enable from the 25 MHz tick divider sets the timing. Outputs are hsync, vsync, a visible-area flag and the current pixel coordinates, which feed the pong pixel/graphics generator and the VGA pins. Timing values are parameters, so other modes need no RTL changes.

---
 rtl/vga_sync_gen.sv | 122 ++++++++++++
 tb/tb_vga_sync_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: per-axis phase FSMs and coordinate counters advanced
// by a pixel-rate enable, with all outputs registered and cycle-coherent.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } phase_e;

  // Phase entered when the counter lands on a boundary. Later phases are tested
  // first so a zero-length porch or sync collapses into the following phase.
  function automatic phase_e next_phase(input logic [9:0] cnt, input phase_e cur,
                                        input logic [9:0] fp_s, input logic [9:0] sync_s,
                                        input logic [9:0] bp_s);
    phase_e nxt;
    nxt = cur;
    if (cnt == bp_s)        nxt = ST_BACK;
    else if (cnt == sync_s) nxt = ST_SYNC;
    else if (cnt == fp_s)   nxt = ST_FRONT;
    else if (cnt == 10'd0)  nxt = ST_ACTIVE;
    return nxt;
  endfunction

  phase_e     h_state_q, h_state_d;
  phase_e     v_state_q, v_state_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    frame_start_d = 1'b0;
    h_wrap        = (h_cnt_q == H_LAST);
    v_wrap        = (v_cnt_q == V_LAST);

    if (pix_tick) begin
      h_cnt_d   = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      h_state_d = next_phase(h_cnt_d, h_state_q, H_FP_START, H_SYNC_START, H_BP_START);
      if (h_wrap) begin
        v_cnt_d       = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        v_state_d     = next_phase(v_cnt_d, v_state_q, V_FP_START, V_SYNC_START, V_BP_START);
        frame_start_d = v_wrap;
      end
    end

    // Flags derive from the next phase so they register alongside the counters.
    hsync_d    = (h_state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = (v_state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    video_on_d = (h_state_d == ST_ACTIVE) && (v_state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_state_q     <= ST_ACTIVE;
      v_state_q     <= ST_ACTIVE;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a reduced raster so whole frames fit in a
// short run; expectations come from a coordinate-level model of the raster rules.
module tb_vga_sync_gen;

  localparam int   HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int   VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam logic POL = 1'b0;

  logic       clk, rst, pix_tick;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          mx = 0, my = 0;
  int          exp_frames = 0, seen_frames = 0;
  logic [23:0] exp_q[$];

  // {hsync, vsync, video_on, frame_start, x, y}
  function automatic logic [23:0] expect_vec(input int x, input int y, input logic fs);
    logic hs, vs, von;
    hs  = (x >= HA + HF && x < HA + HF + HS) ? POL : ~POL;
    vs  = (y >= VA + VF && y < VA + VF + VS) ? POL : ~POL;
    von = (x < HA) && (y < VA);
    return {hs, vs, von, fs, 10'(x), 10'(y)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {hsync, vsync, video_on, frame_start, pixel_x, pixel_y};
  endfunction

  task automatic report(input string name, input logic [23:0] a, input logic [23:0] e);
    errors++;
    $display("FAIL %s t=%0t got hs=%b vs=%b von=%b fs=%b x=%0d y=%0d expected hs=%b vs=%b von=%b fs=%b x=%0d y=%0d",
             name, $time, a[23], a[22], a[21], a[20], a[19:10], a[9:0],
             e[23], e[22], e[21], e[20], e[19:10], e[9:0]);
  endtask

  // One clock of stimulus: drive inputs at the falling edge, advance the model to
  // what the next rising edge should produce, and queue that expectation.
  task automatic step(input logic t, input logic r);
    logic        rise, fs;
    logic [23:0] a, e;
    @(negedge clk);
    rise     = r && !rst;
    rst      = r;
    pix_tick = t;
    if (rise) begin
      #1;
      a = dut_vec();
      e = expect_vec(0, 0, 1'b0);
      checks++;
      if (a !== e) report("async_reset", a, e);
    end
    fs = 1'b0;
    if (r) begin
      mx = 0;
      my = 0;
    end else if (t) begin
      fs = (mx == HT - 1) && (my == VT - 1);
      mx = mx + 1;
      if (mx == HT) begin
        mx = 0;
        my = (my + 1) % VT;
      end
    end
    if (fs) exp_frames++;
    exp_q.push_back(expect_vec(mx, my, fs));
  endtask

  // Monitor: every clock the registered outputs are compared against the queue head.
  initial begin
    logic [23:0] a, e;
    forever begin
      @(posedge clk);
      #2;
      a = dut_vec();
      if (frame_start) seen_frames++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t no expectation queued", $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) report("raster", a, e);
      end
    end
  end

  initial begin
    int guard;
    rst      = 1'b1;
    pix_tick = 1'b0;

    repeat (3) step(1'b0, 1'b1);

    // Tick every 4th clock for two full frames.
    for (int i = 0; i < 4 * 2 * HT * VT; i++) step(i % 4 == 3, 1'b0);

    // Freeze mid-frame, then resume.
    guard = 0;
    while (!(mx == 10 && my == 5) && guard < 2000) begin
      step(1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL freeze_point not reached x=%0d y=%0d required x=10 y=5", mx, my);
    end
    repeat (50) step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // pix_tick tied high for more than two frames.
    repeat (2 * HT * VT + 50) step(1'b1, 1'b0);

    // Irregular tick spacing with rare resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 599) == 0);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b0);

    // Reset while both syncs are asserted.
    guard = 0;
    while (!(mx >= HA + HF && mx < HA + HF + HS && my >= VA + VF && my < VA + VF + VS)
           && guard < 1000) begin
      step(1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      errors++;
      $display("FAIL sync_region not reached x=%0d y=%0d", mx, my);
    end
    step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    repeat (HT * VT + 40) step(1'b1, 1'b0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    checks++;
    if (seen_frames != exp_frames) begin
      errors++;
      $display("FAIL frame_count got %0d required %0d", seen_frames, exp_frames);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
